ok_dram_fifo: RTL and testbench

//   Parametrised single-clock synchronous FIFO on distributed (LUT) dual-port RAM:

---
 rtl/ok_dram_fifo.sv | 88 ++++++++
 tb/tb_ok_dram_fifo.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ok_dram_fifo.sv
// Single-clock FIFO on distributed dual-port RAM with occupancy flags, error strobes
// and selectable first-word-fall-through or registered (1-cycle latency) read port.
module ok_dram_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned FWFT       = 1,
  parameter int unsigned AF_THRESH  = 60,
  parameter int unsigned AE_THRESH  = 4
) (
  input  logic                  wclk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned         DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Flags decode only from the registered count, so wr_en/rd_en never reach them.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

  // RAM array has no reset so it maps onto LUT RAM.
  always_ff @(posedge wclk) begin
    if (wr_acc) mem[wr_ptr] <= din;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign dout  = mem[rd_ptr];
      assign valid = ~empty;
    end else begin : g_std
      always_ff @(posedge wclk or negedge rst_n) begin
        if (!rst_n) begin
          dout  <= '0;
          valid <= 1'b0;
        end else begin
          valid <= rd_acc;
          if (rd_acc) dout <= mem[rd_ptr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ok_dram_fifo.sv
// Randomised and directed bench for ok_dram_fifo: a 64x8 FWFT instance and an 8x16
// standard-mode instance, both checked every cycle against queue-based models.
module tb_ok_dram_fifo;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        wra, rda, wrb, rdb;
  logic [7:0]  dina, a_dout;
  logic [15:0] dinb, b_dout;
  logic        a_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_udf;
  logic        b_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_udf;
  logic [6:0]  a_count;
  logic [3:0]  b_count;

  ok_dram_fifo u_a (
    .wclk(clk), .rst_n(rst_n), .wr_en(wra), .din(dina), .rd_en(rda),
    .dout(a_dout), .valid(a_valid), .full(a_full), .empty(a_empty),
    .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
    .overflow(a_ovf), .underflow(a_udf)
  );

  ok_dram_fifo #(
    .DATA_WIDTH(16), .ADDR_WIDTH(3), .FWFT(0), .AF_THRESH(6), .AE_THRESH(1)
  ) u_b (
    .wclk(clk), .rst_n(rst_n), .wr_en(wrb), .din(dinb), .rd_en(rdb),
    .dout(b_dout), .valid(b_valid), .full(b_full), .empty(b_empty),
    .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
    .overflow(b_ovf), .underflow(b_udf)
  );

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  logic [7:0]  qa[$];
  logic [15:0] qb[$];
  logic        exp_ovfa, exp_udfa, exp_ovfb, exp_udfb, exp_validb;
  logic [15:0] exp_doutb;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int unsigned sa, sb;
    sa = qa.size();
    sb = qb.size();
    check_eq("a_count", 64'(a_count), 64'(sa));
    check_eq("a_empty", 64'(a_empty), 64'(sa == 0));
    check_eq("a_full",  64'(a_full),  64'(sa == 64));
    check_eq("a_af",    64'(a_af),    64'(sa >= 60));
    check_eq("a_ae",    64'(a_ae),    64'(sa <= 4));
    check_eq("a_valid", 64'(a_valid), 64'(sa != 0));
    check_eq("a_ovf",   64'(a_ovf),   64'(exp_ovfa));
    check_eq("a_udf",   64'(a_udf),   64'(exp_udfa));
    if (sa != 0) check_eq("a_dout", 64'(a_dout), 64'(qa[0]));
    check_eq("b_count", 64'(b_count), 64'(sb));
    check_eq("b_cnt_max", 64'(b_count <= 4'd8), 64'd1);
    check_eq("b_empty", 64'(b_empty), 64'(sb == 0));
    check_eq("b_full",  64'(b_full),  64'(sb == 8));
    check_eq("b_af",    64'(b_af),    64'(sb >= 6));
    check_eq("b_ae",    64'(b_ae),    64'(sb <= 1));
    check_eq("b_valid", 64'(b_valid), 64'(exp_validb));
    check_eq("b_dout",  64'(b_dout),  64'(exp_doutb));
    check_eq("b_ovf",   64'(b_ovf),   64'(exp_ovfb));
    check_eq("b_udf",   64'(b_udf),   64'(exp_udfb));
  endtask

  // One clock: drive both instances, advance the models by the pre-edge occupancy rules.
  task automatic step(input logic wa, input logic [7:0] da, input logic ra,
                      input logic wb, input logic [15:0] db, input logic rb);
    logic fa, ea, fb, eb;
    wra = wa; dina = da; rda = ra;
    wrb = wb; dinb = db; rdb = rb;
    fa = (qa.size() == 64); ea = (qa.size() == 0);
    fb = (qb.size() == 8);  eb = (qb.size() == 0);
    exp_ovfa = wa && fa; exp_udfa = ra && ea;
    exp_ovfb = wb && fb; exp_udfb = rb && eb;
    if (ra && !ea) void'(qa.pop_front());
    if (wa && !fa) qa.push_back(da);
    exp_validb = rb && !eb;
    if (exp_validb) exp_doutb = qb.pop_front();
    if (wb && !fb) qb.push_back(db);
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 1'b0;
    wra = 1'b0; rda = 1'b0; wrb = 1'b0; rdb = 1'b0;
    dina = '0; dinb = '0;
    exp_ovfa = 1'b0; exp_udfa = 1'b0; exp_ovfb = 1'b0; exp_udfb = 1'b0;
    exp_validb = 1'b0; exp_doutb = '0;
    #7 rst_n = 1'b1;

    // Mid-burst asynchronous reset: flags must clear without a clock edge.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(i + 8'h40), 1'b0, 1'b1, 16'(i + 16'h100), i == 3);
    #2 rst_n = 1'b0;
    #1;
    qa.delete(); qb.delete();
    exp_ovfa = 1'b0; exp_udfa = 1'b0; exp_ovfb = 1'b0; exp_udfb = 1'b0;
    exp_validb = 1'b0; exp_doutb = '0;
    check_all();
    wra = 1'b0; wrb = 1'b0; rda = 1'b0; rdb = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Fill 0x00..0x3F, then overflow on the 65th write.
    for (int i = 0; i < 64; i++) step(1'b1, 8'(i), 1'b0, 1'b0, '0, 1'b0);
    step(1'b1, 8'hEE, 1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, '0, 1'b0);
    // Drain in order, then underflow.
    for (int i = 0; i < 64; i++) step(1'b0, 8'h00, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, '0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, '0, 1'b0);

    // Standard mode: single write then pop, valid/dout one cycle after the read edge.
    step(1'b0, 8'h00, 1'b0, 1'b1, 16'h00A5, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, '0, 1'b1);
    check_eq("b_a5_dout", 64'(b_dout), 64'h00A5);
    step(1'b0, 8'h00, 1'b0, 1'b0, '0, 1'b0);

    // Simultaneous push/pop at empty, full and mid occupancy.
    step(1'b1, 8'h11, 1'b1, 1'b1, 16'h2222, 1'b1);
    for (int i = 0; i < 63; i++) step(1'b1, 8'($urandom), 1'b0, 1'b1, 16'($urandom), 1'b0);
    step(1'b1, 8'h33, 1'b1, 1'b1, 16'h4444, 1'b1);
    while (qa.size() > 10) step(1'b0, 8'h00, 1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b1, 8'($urandom), 1'b1, 1'b1, 16'($urandom), 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1, 1'b0, '0, 1'b1);

    // Random traffic with phases biased toward filling and toward draining.
    for (int i = 0; i < 400; i++) begin
      int unsigned pw, pr;
      pw = ((i / 40) % 2 == 0) ? 80 : 25;
      pr = ((i / 40) % 2 == 0) ? 30 : 80;
      step($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) < pr,
           $urandom_range(0, 99) < pw, 16'($urandom), $urandom_range(0, 99) < pr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
